// File: rtl/core_pkg.sv
// Shared pipeline encodings: writeback sources, forwarding selects and the
// hazard controller state encoding.
package core_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational EX operand forwarding select for one source register.
module fwd_unit
    import core_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_dst,
    input  logic       mem_regwrite,
    input  logic [1:0] mem_wbselect,
    input  logic [4:0] wb_dst,
    input  logic       wb_regwrite,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        // A load in EX/MEM has no data yet, so only ALU/PC4 results forward from there.
        if (mem_regwrite && (mem_dst != 5'd0) && (mem_wbselect != WB_MEM) && (mem_dst == ex_rs)) begin
            fwd = FWD_EXMEM;
        end else if (wb_regwrite && (wb_dst != 5'd0) && (wb_dst == ex_rs)) begin
            fwd = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch squashes, data-memory
// waits with timeout, EX forwarding selects and saturating perf counters.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_dst,
    input  logic             ex_regwrite,
    input  logic [1:0]       ex_wbselect,
    input  logic             ex_branch_taken,
    input  logic [4:0]       mem_dst,
    input  logic             mem_regwrite,
    input  logic [1:0]       mem_wbselect,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic [4:0]       wb_dst,
    input  logic             wb_regwrite,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic             load_use;
    logic             mem_stall;
    logic [1:0]       fwd_a_raw, fwd_b_raw;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

    fwd_unit u_fwd_a (
        .ex_rs        (ex_rs1),
        .mem_dst      (mem_dst),
        .mem_regwrite (mem_regwrite),
        .mem_wbselect (mem_wbselect),
        .wb_dst       (wb_dst),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .ex_rs        (ex_rs2),
        .mem_dst      (mem_dst),
        .mem_regwrite (mem_regwrite),
        .mem_wbselect (mem_wbselect),
        .wb_dst       (wb_dst),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_b_raw)
    );

    assign load_use = ex_regwrite && (ex_wbselect == WB_MEM) && (ex_dst != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_dst)) || (id_use_rs2 && (id_rs2 == ex_dst)));
    assign mem_stall = mem_access && !dmem_ready;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_d     = stall_q;
        flush_d     = flush_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        fwd_a       = fwd_a_raw;
        fwd_b       = fwd_b_raw;

        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            fwd_a       = FWD_RF;
            fwd_b       = FWD_RF;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        state_d     = ST_MEM_WAIT;
                        wait_cnt_d  = 8'd1;
                    end else if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        flush_d     = sat_inc(flush_q);
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_flush  = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_d     = ST_RUN;
                        wait_cnt_d  = 8'd0;
                    end else begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        if (wait_cnt_q == TIMEOUT) begin
                            state_d   = ST_ERR;
                            mem_err_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    idex_en   = 1'b0;
                    exmem_en  = 1'b0;
                    memwb_en  = 1'b0;
                    mem_err_d = 1'b1;
                end
            endcase

            // ERR freezes the pipeline but is not a counted stall.
            if (!pc_en && (state_q != ST_ERR)) begin
                stall_d = sat_inc(stall_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares every cycle.
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_dst, mem_dst, wb_dst;
    logic id_use_rs1, id_use_rs2, ex_regwrite, ex_branch_taken;
    logic mem_regwrite, mem_access, dmem_ready, wb_regwrite;
    logic [1:0] ex_wbselect, mem_wbselect;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [1:0] fwd_a, fwd_b;
    logic mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    typedef struct packed {
        logic [4:0] en;   // pc, ifid, idex, exmem, memwb
        logic [3:0] fl;   // ifid, idex, exmem, memwb
        logic [1:0] fa;
        logic [1:0] fb;
        logic       err;
        logic [2:0] st;
        logic [2:0] fe;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_id   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_dst(ex_dst), .ex_regwrite(ex_regwrite),
        .ex_wbselect(ex_wbselect), .ex_branch_taken(ex_branch_taken),
        .mem_dst(mem_dst), .mem_regwrite(mem_regwrite), .mem_wbselect(mem_wbselect),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .wb_dst(wb_dst), .wb_regwrite(wb_regwrite),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    function automatic exp_t E(input logic [4:0] en, input logic [3:0] fl, input logic [1:0] fa,
                               input logic [1:0] fb, input logic err, input logic [2:0] st,
                               input logic [2:0] fe);
        exp_t e;
        e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.err = err; e.st = st; e.fe = fe;
        return e;
    endfunction

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_dst = 0; ex_regwrite = 0; ex_wbselect = 0; ex_branch_taken = 0;
        mem_dst = 0; mem_regwrite = 0; mem_wbselect = 0; mem_access = 0; dmem_ready = 0;
        wb_dst = 0; wb_regwrite = 0;
    endtask

    task automatic step(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input int v, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL vec%0d %s: got %0h expected %0h", v, name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vec_id++;
            cmp("en",     vec_id, {3'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {3'b0, e.en});
            cmp("flush",  vec_id, {4'b0, ifid_flush, idex_flush, exmem_flush, memwb_flush}, {4'b0, e.fl});
            cmp("fwd_a",  vec_id, {6'b0, fwd_a}, {6'b0, e.fa});
            cmp("fwd_b",  vec_id, {6'b0, fwd_b}, {6'b0, e.fb});
            cmp("mem_err",vec_id, {7'b0, mem_err}, {7'b0, e.err});
            cmp("stall",  vec_id, {5'b0, stall_cycles}, {5'b0, e.st});
            cmp("flushev",vec_id, {5'b0, flush_events}, {5'b0, e.fe});
        end
    end

    initial begin
        clr();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset: all en/flush high, forwarding forced to RF even with a match present
        mem_regwrite = 1; mem_dst = 3; ex_rs1 = 3;
        step(E(5'b11111, 4'b1111, 2'd0, 2'd0, 0, 0, 0));
        rst_n = 1'b1; clr();
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 0, 0));

        // load-use on rs1
        ex_wbselect = 2'd1; ex_regwrite = 1; ex_dst = 5; id_rs1 = 5; id_use_rs1 = 1;
        step(E(5'b00111, 4'b0100, 2'd0, 2'd0, 0, 0, 0));
        clr();
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 1, 0));
        // match on rs2 but rs2 not used: no stall
        ex_wbselect = 2'd1; ex_regwrite = 1; ex_dst = 7; id_rs2 = 7; id_use_rs2 = 0;
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 1, 0));
        // load to x0: no stall
        ex_dst = 0; id_rs1 = 0; id_use_rs1 = 1;
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 1, 0));
        // load-use on rs2
        ex_dst = 9; id_rs2 = 9; id_use_rs2 = 1; id_use_rs1 = 0;
        step(E(5'b00111, 4'b0100, 2'd0, 2'd0, 0, 1, 0));
        clr();

        // forwarding
        mem_regwrite = 1; mem_dst = 3; mem_wbselect = 2'd0; wb_regwrite = 1; wb_dst = 3;
        ex_rs1 = 3; ex_rs2 = 3;
        step(E(5'b11111, 4'b0000, 2'd1, 2'd1, 0, 2, 0));
        mem_regwrite = 0;
        step(E(5'b11111, 4'b0000, 2'd2, 2'd2, 0, 2, 0));
        wb_dst = 0;
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 2, 0));
        mem_regwrite = 1; mem_wbselect = 2'd1; wb_dst = 3;
        step(E(5'b11111, 4'b0000, 2'd2, 2'd2, 0, 2, 0));
        mem_wbselect = 2'd2; wb_dst = 4; ex_rs2 = 4;
        step(E(5'b11111, 4'b0000, 2'd1, 2'd2, 0, 2, 0));
        clr();

        // branch overrides coincident load-use
        ex_branch_taken = 1; ex_wbselect = 2'd1; ex_regwrite = 1; ex_dst = 5; id_rs1 = 5; id_use_rs1 = 1;
        step(E(5'b11111, 4'b1100, 2'd0, 2'd0, 0, 2, 0));
        clr();
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 2, 1));

        // completed access in RUN: no stall
        mem_access = 1; dmem_ready = 1;
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 2, 1));
        // memory wait 3 cycles (branch ignored on first), release on 4th
        dmem_ready = 0; ex_branch_taken = 1;
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 2, 1));
        ex_branch_taken = 0;
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 3, 1));
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 4, 1));
        dmem_ready = 1;
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 5, 1));
        clr();
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 5, 1));

        // timeout into ERR; stall counter saturates at 7
        mem_access = 1; dmem_ready = 0;
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 5, 1));
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 6, 1));
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 7, 1));
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 7, 1));
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 7, 1));
        step(E(5'b00000, 4'b0000, 2'd0, 2'd0, 1, 7, 1));
        // ERR is sticky even with dmem_ready; forwarding still live
        dmem_ready = 1; mem_regwrite = 1; mem_dst = 2; ex_rs1 = 2;
        step(E(5'b00000, 4'b0000, 2'd1, 2'd0, 1, 7, 1));
        rst_n = 1'b0;
        step(E(5'b11111, 4'b1111, 2'd0, 2'd0, 1, 7, 1));
        rst_n = 1'b1; clr();
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 0, 0));

        // reset in second MEM_WAIT cycle
        mem_access = 1; dmem_ready = 0;
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 0, 0));
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 1, 0));
        rst_n = 1'b0;
        step(E(5'b11111, 4'b1111, 2'd0, 2'd0, 0, 2, 0));
        rst_n = 1'b1;
        // wait_cnt restarted: ready exactly at wait_cnt==MEM_TIMEOUT succeeds
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 0, 0));
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 1, 0));
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 2, 0));
        step(E(5'b00001, 4'b0001, 2'd0, 2'd0, 0, 3, 0));
        dmem_ready = 1;
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 4, 0));
        clr();
        step(E(5'b11111, 4'b0000, 2'd0, 2'd0, 0, 4, 0));

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
